// File: rtl/fproc_responder.sv
//------------------------------------------------------------------------------
// fproc_responder: per-core measurement-lookup responder; each core holds one
// outstanding request and gets a one-cycle ready pulse with held result data.
// Optional macro FPROC_TIMEOUT_EN adds a per-core wait watchdog.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fproc_responder #(
   parameter int N_CORES        = 4,
   parameter int N_MEAS         = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int FPROC_ID_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [N_CORES-1:0]                 fproc_en,
   input  logic [N_CORES*FPROC_ID_WIDTH-1:0]  fproc_id,
   input  logic [N_MEAS-1:0]                  meas,
   input  logic [N_MEAS-1:0]                  meas_valid,
   output logic [N_CORES-1:0]                 fproc_ready,
   output logic [N_CORES*DATA_WIDTH-1:0]      fproc_data,
   output logic [N_CORES-1:0]                 fproc_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int IDX_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
   // One extra bit so N_MEAS itself is representable in the range check.
   localparam logic [FPROC_ID_WIDTH:0] N_MEAS_EXT = (FPROC_ID_WIDTH+1)'(N_MEAS);

`ifdef FPROC_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
   localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

   for (genvar c = 0; c < N_CORES; c++) begin : g_core
      state_t                    state_q, state_d;
      logic [IDX_W-1:0]          idx_q, idx_d;
      logic                      ready_q, ready_d;
      logic                      err_q, err_d;
      logic [DATA_WIDTH-1:0]     data_q, data_d;
      logic [FPROC_ID_WIDTH-1:0] req_id;
      logic                      req_oob;
      logic [IDX_W-1:0]          sel_idx;
      logic                      sel_meas;
      logic                      sel_valid;
`ifdef FPROC_TIMEOUT_EN
      logic [CNT_W-1:0]          cnt_q, cnt_d;
      logic [CNT_W-1:0]          cnt_inc;
      assign cnt_inc = cnt_q + 1'b1;
`endif

      assign req_id  = fproc_id[c*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
      assign req_oob = {1'b0, req_id} >= N_MEAS_EXT;
      assign sel_idx = (state_q == ST_IDLE) ? req_id[IDX_W-1:0] : idx_q;

      // Compare-based select so no index beyond N_MEAS-1 is ever read.
      always_comb begin
         sel_meas  = 1'b0;
         sel_valid = 1'b0;
         for (int m = 0; m < N_MEAS; m++) begin
            if (sel_idx == IDX_W'(m)) begin
               sel_meas  = meas[m];
               sel_valid = meas_valid[m];
            end
         end
      end

      always_comb begin
         state_d = state_q;
         idx_d   = idx_q;
         ready_d = 1'b0;
         err_d   = 1'b0;
         data_d  = data_q;
`ifdef FPROC_TIMEOUT_EN
         cnt_d   = cnt_q;
`endif
         case (state_q)
            ST_IDLE: begin
               if (fproc_en[c]) begin
                  if (req_oob) begin
                     state_d = ST_RESP;
                     ready_d = 1'b1;
                     err_d   = 1'b1;
                     data_d  = '0;
                  end else if (sel_valid) begin
                     state_d = ST_RESP;
                     ready_d = 1'b1;
                     data_d  = {{(DATA_WIDTH-1){1'b0}}, sel_meas};
                  end else begin
                     state_d = ST_WAIT;
                     idx_d   = req_id[IDX_W-1:0];
`ifdef FPROC_TIMEOUT_EN
                     cnt_d   = '0;
`endif
                  end
               end
            end
            ST_WAIT: begin
               if (sel_valid) begin
                  state_d = ST_RESP;
                  ready_d = 1'b1;
                  data_d  = {{(DATA_WIDTH-1){1'b0}}, sel_meas};
`ifdef FPROC_TIMEOUT_EN
               end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_d = ST_RESP;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  data_d  = '1;
               end else begin
                  cnt_d   = cnt_inc;
`endif
               end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
`ifdef FPROC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
         end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            data_q  <= data_d;
`ifdef FPROC_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
         end
      end

      assign fproc_ready[c]                       = ready_q;
      assign fproc_err[c]                         = err_q;
      assign fproc_data[c*DATA_WIDTH +: DATA_WIDTH] = data_q;
   end

endmodule

`default_nettype wire

// File: doc/fproc_responder.md
Name: fproc_responder

Overview:
- Function-processor responder: the far end of the per-core fproc request interface driven by each processor core.
- Accepts one outstanding measurement-lookup request per core (fproc_en pulse plus fproc_id).
- Waits for the addressed measurement channel to deliver a result, then returns it with a single-cycle fproc_ready pulse and held fproc_data.
- Sits at top level between the N processor cores and the readout/measurement discriminator outputs.

Parameters:
- N_CORES, 4, number of processor cores served.
- N_MEAS, 8, number of measurement channels.
- DATA_WIDTH, 32, width of the fproc_data returned to each core.
- FPROC_ID_WIDTH, 8, width of each core's fproc_id.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only when FPROC_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- fproc_en  input  N_CORES  per-core request strobe, one cycle wide.
- fproc_id  input  N_CORES*FPROC_ID_WIDTH  per-core channel index; core c occupies bits [c*FPROC_ID_WIDTH +: FPROC_ID_WIDTH].
- meas  input  N_MEAS  per-channel measurement result bit.
- meas_valid  input  N_MEAS  per-channel strobe qualifying meas.
- fproc_ready  output  N_CORES  per-core response strobe, one cycle wide.
- fproc_data  output  N_CORES*DATA_WIDTH  per-core response data; core c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- fproc_err  output  N_CORES  per-core error strobe, coincident with fproc_ready.

Behaviour:
- Reset (reset low, asynchronous):
  - All per-core FSMs go to IDLE.
  - fproc_ready, fproc_err and fproc_data are 0.
  - All latched ids are 0.
  - A request in flight is dropped; no response is issued after reset releases.
- Each core has an independent FSM with states IDLE, WAIT and RESP. Cores never block each other.
- IDLE:
  - fproc_en[c] high with fproc_id >= N_MEAS: go to RESP with data 0 and the error flag set.
  - fproc_en[c] high with fproc_id < N_MEAS and meas_valid[id] high in the same cycle: go to RESP, capturing meas[id].
  - fproc_en[c] high otherwise: latch the id and go to WAIT.
- WAIT:
  - On the first cycle with meas_valid[latched id] high, capture meas[id] and go to RESP.
  - Measurements that arrived before the request cycle are never used; there is no stale-data return.
- RESP (one cycle):
  - fproc_ready[c] = 1.
  - fproc_data[c] = zero-extended captured bit ({DATA_WIDTH-1 zeros, meas}).
  - fproc_err[c] = error flag.
  - Next state is IDLE.
- Output timing:
  - All outputs are registered.
  - Latency is 1 cycle from the capture cycle to fproc_ready.
  - Minimum latency is 1 cycle from fproc_en, when meas_valid arrives in the same cycle.
- fproc_data[c] holds its value after fproc_ready until the next response for core c.
- fproc_en[c] asserted in WAIT or RESP is ignored: no queueing and no state change. Re-issue is legal in the cycle after RESP, once the FSM is back in IDLE.
- Several cores waiting on the same channel are all released by the same meas_valid pulse and respond in the same cycle.
- meas_valid on channels nobody is waiting for is discarded.
- The id is compared with an unsigned >= against N_MEAS. Index logic must not read past N_MEAS-1.

Optional Feature:
- Macro: FPROC_TIMEOUT_EN.
- Defined:
  - Each core has a wait counter, clog2(TIMEOUT_CYCLES+1) bits wide.
  - The counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - When it reaches TIMEOUT_CYCLES with no meas_valid, the core goes to RESP with fproc_data all-ones and fproc_err = 1.
  - If meas_valid arrives in the same cycle as the timeout, the measurement wins.
- Not defined:
  - No counter logic is present.
  - WAIT persists until meas_valid or reset.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Core0 sends fproc_en with id=3 at t; meas_valid[3]=1 with meas[3]=1 at t+5 -> fproc_ready[0]=1 at t+6 only, fproc_data[0]=0x00000001, fproc_err[0]=0.
- Core1 sends id=2 at t with meas_valid[2]=1 and meas[2]=0 in the same cycle -> ready at t+1, data 0x00000000. A meas_valid[2] at t-1 must be ignored.
- Cores 0, 2 and 3 all request id=5; a single meas_valid[5] pulse with meas=1 -> all three fproc_ready assert in the same cycle, each with data 0x1.
- Core3 sends id=8 (N_MEAS=8) -> ready at t+1, fproc_err[3]=1, data 0. A second fproc_en sent during a core's WAIT -> ignored, and exactly one response is produced.
- Drive reset low while core0 is in WAIT, release it, then pulse meas_valid -> no fproc_ready is produced and all outputs read 0.
- With FPROC_TIMEOUT_EN and TIMEOUT_CYCLES=16, a request with no meas_valid -> ready at t+17 with data 0xFFFFFFFF and err=1. A meas_valid in the timeout cycle -> the measured data is returned with err=0.
